// File: rtl/mux_rr_arb_pkg.sv
// Shared types and helpers for the round-robin select mux.
// Imported by the interface, the grant picker and the top level.
package mux_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 8;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic arb_mode_e to_mode(input int rr);
    return (rr != 0) ? ARB_RR : ARB_FIXED;
  endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Producer/consumer bundle of the arbitrated mux.
// slave = arbiter side, master = environment side.
interface mux_rr_arb_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  localparam int SELW = sel_width(CHANNELS);

  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0][WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_ready;
  logic                           out_valid;
  logic [WIDTH-1:0]               out_data;
  logic [SELW-1:0]                out_sel;
  logic                           out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

endinterface

// File: rtl/mux_rr_arb_rr_grant.sv
// Rotating-priority picker: first requester at or after ptr wins.
// Fixed priority is obtained by tying ptr to zero.
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SELW-1:0]     i_ptr,
  input  logic                i_en,
  output logic [CHANNELS-1:0] o_grant,
  output logic [SELW-1:0]     o_idx,
  output logic                o_any
);

  int w_j;

  // Scan ptr..CHANNELS-1 then 0..ptr-1, keep first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int off = 0; off < CHANNELS; off++) begin
      w_j = int'(i_ptr) + off;
      if (w_j >= CHANNELS) w_j = w_j - CHANNELS;
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = SELW'(w_j);
      end
    end
    if (i_en && o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel arbitrated select mux with a one-entry
// registered output stage (valid/ready both sides).
module mux_rr_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RR_MODE  = 1
) (
  input  logic         clk,
  input  logic         rst,
  mux_rr_arb_if.slave  bus
);

  localparam int        SELW = sel_width(CHANNELS);
  localparam arb_mode_e MODE = to_mode(RR_MODE);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]     r_ptr;
  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SELW-1:0]     r_sel;

  logic                w_load;
  logic                w_en;
  logic                w_any;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_grant;
  logic [SELW-1:0]     w_idx;
  logic [SELW-1:0]     w_ptr;
  logic [SELW-1:0]     w_ptr_nxt;

  // Output slot is free, or is being emptied this cycle.
  assign w_load = !r_valid || bus.out_ready;
  assign w_en   = w_load && !rst;

  assign w_ptr = (MODE == ARB_RR) ? r_ptr : '0;

  rr_grant #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_grant (
    .i_req   (bus.in_valid),
    .i_ptr   (w_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_xfer = w_en && w_any;

  // Explicit wrap so non power-of-2 counts never reach unused codes.
  assign w_ptr_nxt = (w_idx == LAST) ? '0 : w_idx + 1'b1;

  assign bus.in_ready  = w_grant;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

  // Output register and rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= bus.in_data[w_idx];
      r_sel   <= w_idx;
      if (MODE == ARB_RR) r_ptr <= w_ptr_nxt;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: RR x8, RR x5 and
// fixed-priority x8 instances share one stimulus stream.
module tb_mux_rr_arb;
  import mux_arb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      vld;
  logic [7:0][15:0] dat;
  logic [7:0][15:0] dat_n;
  logic            ordy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int C  = (g == 1) ? 5 : 8;
    localparam int RR = (g == 2) ? 0 : 1;

    mux_rr_arb_if #(.WIDTH(16), .CHANNELS(C)) bus ();

    mux_rr_arb #(
      .WIDTH    (16),
      .CHANNELS (C),
      .RR_MODE  (RR)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.in_valid  = vld[C-1:0];
    assign bus.in_data   = dat[C-1:0];
    assign bus.out_ready = ordy;

    int          m_ptr = 0;
    bit          m_full = 1'b0;
    int          q_sel[$];
    logic [15:0] q_dat[$];
    bit          stall = 1'b0;
    logic [15:0] l_d;
    logic [31:0] l_s;
    logic [C-1:0] m_er;
    int          m_k;
    bit          m_f;
    int          p_s;
    logic [15:0] p_d;

    always @(negedge clk) begin
      #1;
      chk($sformatf("c%0d_valid", g), 32'(bus.out_valid), 32'(m_full));
      if (bus.out_valid && !ordy) begin
        if (stall) begin
          chk($sformatf("c%0d_stall_data", g), 32'(bus.out_data), 32'(l_d));
          chk($sformatf("c%0d_stall_sel", g), 32'(bus.out_sel), l_s);
        end
        stall = 1'b1;
        l_d = bus.out_data;
        l_s = 32'(bus.out_sel);
      end else begin
        stall = 1'b0;
      end
      if (bus.out_valid && ordy && !rst) begin
        if (q_sel.size() == 0) begin
          chk($sformatf("c%0d_underflow", g), 32'd1, 32'd0);
        end else begin
          p_s = q_sel.pop_front();
          p_d = q_dat.pop_front();
          chk($sformatf("c%0d_sel", g), 32'(bus.out_sel), 32'(p_s));
          chk($sformatf("c%0d_data", g), 32'(bus.out_data), 32'(p_d));
        end
      end
      #1;
      m_er = '0;
      m_f  = 1'b0;
      m_k  = 0;
      if (!rst && (!m_full || ordy)) begin
        for (int off = 0; off < C; off++) begin
          if (!m_f && vld[(m_ptr + off) % C]) begin
            m_f = 1'b1;
            m_k = (m_ptr + off) % C;
          end
        end
      end
      if (m_f) m_er[m_k] = 1'b1;
      chk($sformatf("c%0d_in_ready", g), 32'(bus.in_ready), 32'(m_er));
      if (rst) begin
        m_full = 1'b0;
        m_ptr  = 0;
        q_sel.delete();
        q_dat.delete();
        stall  = 1'b0;
      end else if (m_f) begin
        q_sel.push_back(m_k);
        q_dat.push_back(dat[m_k]);
        m_full = 1'b1;
        if (RR != 0) m_ptr = (m_k + 1) % C;
      end else if (ordy) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic cyc(input logic r, input logic [7:0] v, input logic o);
    @(negedge clk);
    rst  = r;
    vld  = v;
    ordy = o;
    dat  = dat_n;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dat_n[i] = 16'h00A0 + 16'(i);
    dat  = dat_n;
    rst  = 1'b1;
    vld  = 8'hFF;
    ordy = 1'b0;

    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    #3;
    chk("rst_ready", 32'(cfg[0].bus.in_ready), 32'd0);
    chk("rst_valid", 32'(cfg[0].bus.out_valid), 32'd0);
    chk("rst_data", 32'(cfg[0].bus.out_data), 32'd0);
    chk("rst_sel", 32'(cfg[0].bus.out_sel), 32'd0);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      #3;
      if (i > 0) begin
        chk("rot_sel", 32'(cfg[0].bus.out_sel), 32'((i - 1) % 8));
        chk("rot_data", 32'(cfg[0].bus.out_data),
            32'(16'h00A0 + 16'((i - 1) % 8)));
      end
    end

    cyc(1'b0, 8'h04, 1'b1);
    cyc(1'b0, 8'h84, 1'b1); #3;
    chk("wrap_a", 32'(cfg[0].bus.out_sel), 32'd2);
    cyc(1'b0, 8'h84, 1'b1); #3;
    chk("wrap_b", 32'(cfg[0].bus.out_sel), 32'd7);
    cyc(1'b0, 8'h84, 1'b1); #3;
    chk("wrap_c", 32'(cfg[0].bus.out_sel), 32'd2);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("wrap_d", 32'(cfg[0].bus.out_sel), 32'd7);

    cyc(1'b0, 8'h08, 1'b1);
    cyc(1'b0, 8'h12, 1'b1); #3;
    chk("c5_a", 32'(cfg[1].bus.out_sel), 32'd3);
    cyc(1'b0, 8'h12, 1'b1); #3;
    chk("c5_b", 32'(cfg[1].bus.out_sel), 32'd4);
    cyc(1'b0, 8'h12, 1'b1); #3;
    chk("c5_c", 32'(cfg[1].bus.out_sel), 32'd1);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("c5_d", 32'(cfg[1].bus.out_sel), 32'd4);

    cyc(1'b0, 8'h00, 1'b1);
    dat_n[3] = 16'hBEEF;
    dat_n[5] = 16'h5555;
    cyc(1'b0, 8'h08, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h20, 1'b0); #3;
      chk("bp_valid", 32'(cfg[0].bus.out_valid), 32'd1);
      chk("bp_data", 32'(cfg[0].bus.out_data), 32'hBEEF);
      chk("bp_sel", 32'(cfg[0].bus.out_sel), 32'd3);
      chk("bp_ready", 32'(cfg[0].bus.in_ready), 32'd0);
    end
    cyc(1'b0, 8'h20, 1'b1); #3;
    chk("bp_rel_ready", 32'(cfg[0].bus.in_ready), 32'h20);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("bp_next_sel", 32'(cfg[0].bus.out_sel), 32'd5);
    chk("bp_next_data", 32'(cfg[0].bus.out_data), 32'h5555);

    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 8'h42, 1'b1); #3;
      chk("fix_ready", 32'(cfg[2].bus.in_ready), 32'h02);
      if (i > 0) chk("fix_sel", 32'(cfg[2].bus.out_sel), 32'd1);
    end
    cyc(1'b0, 8'h40, 1'b1); #3;
    chk("fix_last1", 32'(cfg[2].bus.out_sel), 32'd1);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("fix_ch6", 32'(cfg[2].bus.out_sel), 32'd6);

    cyc(1'b0, 8'h01, 1'b0);
    cyc(1'b0, 8'h00, 1'b0); #3;
    chk("mrst_held", 32'(cfg[0].bus.out_valid), 32'd1);
    cyc(1'b1, 8'h00, 1'b0); #3;
    chk("mrst_hold2", 32'(cfg[0].bus.out_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("mrst_clear", 32'(cfg[0].bus.out_valid), 32'd0);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'h00, 1'b1); #3;
    chk("mrst_ptr0", 32'(cfg[0].bus.out_sel), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 8; c++) dat_n[c] = 16'($urandom);
      cyc(($urandom_range(0, 99) == 0), 8'($urandom),
          ($urandom_range(0, 9) < 7));
    end

    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    #3;
    chk("drain0", 32'(cfg[0].q_sel.size()), 32'd0);
    chk("drain1", 32'(cfg[1].q_sel.size()), 32'd0);
    chk("drain2", 32'(cfg[2].q_sel.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
